// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator: beam counters, sync pulses, active-video flag
// and line/frame start strobes, all registered and advanced by a pixel clock enable.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  if (H_TOTAL > 1024) begin : g_h_total_check
    $error("vga_timing_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > 1024) begin : g_v_total_check
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end

  logic       h_wrap;
  logic       v_wrap;
  logic [9:0] next_h;
  logic [9:0] next_v;
  logic       next_hs_act;
  logic       next_vs_act;
  logic       next_de;

  // Sync and active-video are decoded from the next counter values so that once
  // registered they line up with the hpos/vpos shown on the same cycle.
  always_comb begin
    h_wrap      = (hpos == H_LAST);
    v_wrap      = (vpos == V_LAST);
    next_h      = h_wrap ? 10'd0 : hpos + 10'd1;
    next_v      = vpos;
    if (h_wrap) begin
      next_v = v_wrap ? 10'd0 : vpos + 10'd1;
    end
    next_hs_act = (int'(next_h) >= HS_START) && (int'(next_h) < HS_END);
    next_vs_act = (int'(next_v) >= VS_START) && (int'(next_v) < VS_END);
    next_de     = (int'(next_h) < H_ACTIVE) && (int'(next_v) < V_ACTIVE);
  end

  // Reset parks the beam on the last back-porch pixel so the first enable
  // lands on (0,0) and fires both strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos        <= H_LAST;
      vpos        <= V_LAST;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      display_on  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce) begin
      hpos        <= next_h;
      vpos        <= next_v;
      hsync       <= next_hs_act ? SYNC_POL : ~SYNC_POL;
      vsync       <= next_vs_act ? SYNC_POL : ~SYNC_POL;
      display_on  <= next_de;
      line_start  <= h_wrap;
      frame_start <= h_wrap && v_wrap;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

  ce_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(ce))
    else $error("vga_timing_gen: ce is X/Z");

endmodule
